// File: rtl/mach_v_pkg.sv
// Shared store-path definitions: size encodings, FSM states and funct3 width.
package mach_v_pkg;

    localparam int unsigned FUNCT3_W = 3;

    typedef enum logic [1:0] {
        SizeB = 2'b00,
        SizeH = 2'b01,
        SizeW = 2'b10,
        SizeD = 2'b11
    } storeSize_e;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Beat0 = 2'd1,
        Beat1 = 2'd2
    } storeState_e;

endpackage

// File: rtl/store_lane_align.sv
// Places a right-justified access of the given size at byte offset off inside a
// double-width window, flagging word crossing and natural misalignment.
module store_lane_align
    import mach_v_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned BYTES = XLEN / 8,
    localparam int unsigned OFS = $clog2(BYTES)
) (
    input  storeSize_e           size,
    input  logic [OFS-1:0]       off,
    input  logic [XLEN-1:0]      wdata,
    output logic [2*BYTES-1:0]   mask,
    output logic [2*XLEN-1:0]    data,
    output logic                 crossing,
    output logic                 misaligned
);

    logic [3:0]         nBytes;
    logic [2*BYTES-1:0] sizeMask;

    always_comb begin
        nBytes     = 4'd1 << size;
        sizeMask   = (2*BYTES)'((9'd1 << nBytes) - 9'd1);
        mask       = sizeMask << off;
        data       = (2*XLEN)'(wdata) << {off, 3'b000};
        crossing   = (5'(off) + 5'(nBytes)) > 5'(BYTES);
        misaligned = (4'(off) & (nBytes - 4'd1)) != 4'd0;
    end

endmodule

// File: rtl/misaligned_store_unit.sv
// Store unit that issues aligned memory beats, splitting word-crossing stores in two
// (SPLIT_EN=1) or rejecting misaligned ones (SPLIT_EN=0).
module misaligned_store_unit
    import mach_v_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter bit SPLIT_EN = 1'b1,
    localparam int unsigned BYTES = XLEN / 8,
    localparam int unsigned OFS = $clog2(BYTES)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [XLEN-1:0]     addr,
    input  logic [XLEN-1:0]     wdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [BYTES-1:0]    mem_wstrb,
    output logic                store_done,
    output logic                store_fault
);

    storeState_e        state;
    storeSize_e         reqSize;
    logic [OFS-1:0]     reqOff;
    logic [XLEN-1:0]    reqBase;
    logic [2*BYTES-1:0] laneMask;
    logic [2*XLEN-1:0]  laneData;
    logic               crossing;
    logic               misaligned;
    logic               illegalSize;
    logic               reject;
    logic               split;
    logic [XLEN-1:0]    baseAddr;
    logic [BYTES-1:0]   hiStrb;
    logic [XLEN-1:0]    hiData;
    logic               unusedFunct3;

    assign reqSize      = storeSize_e'(funct3[1:0]);
    assign reqOff       = addr[OFS-1:0];
    assign reqBase      = {addr[XLEN-1:OFS], {OFS{1'b0}}};
    assign unusedFunct3 = funct3[2];
    assign illegalSize  = (XLEN == 32) && (reqSize == SizeD);
    assign reject       = illegalSize || (!SPLIT_EN && misaligned);

    store_lane_align #(
        .XLEN(XLEN)
    ) uAlign (
        .size       (reqSize),
        .off        (reqOff),
        .wdata      (wdata),
        .mask       (laneMask),
        .data       (laneData),
        .crossing   (crossing),
        .misaligned (misaligned)
    );

    assign req_ready  = (state == Idle);
    // Done fires in the cycle the final beat handshakes, so IDLE follows it directly.
    assign store_done = mem_valid && mem_ready &&
                        ((state == Beat1) || ((state == Beat0) && !split));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= Idle;
            mem_valid   <= 1'b0;
            mem_addr    <= '0;
            mem_wstrb   <= '0;
            mem_wdata   <= '0;
            store_fault <= 1'b0;
            split       <= 1'b0;
            baseAddr    <= '0;
            hiStrb      <= '0;
            hiData      <= '0;
        end else begin
            store_fault <= 1'b0;
            unique case (state)
                Idle: begin
                    if (req_valid) begin
                        if (reject) begin
                            store_fault <= 1'b1;
                        end else begin
                            state     <= Beat0;
                            mem_valid <= 1'b1;
                            mem_addr  <= reqBase;
                            mem_wstrb <= laneMask[BYTES-1:0];
                            mem_wdata <= laneData[XLEN-1:0];
                            // Upper half of the window is parked for a possible second beat.
                            hiStrb    <= laneMask[2*BYTES-1:BYTES];
                            hiData    <= laneData[2*XLEN-1:XLEN];
                            split     <= SPLIT_EN && crossing;
                            baseAddr  <= reqBase;
                        end
                    end
                end
                Beat0: begin
                    if (mem_ready) begin
                        if (split) begin
                            state     <= Beat1;
                            mem_addr  <= baseAddr + XLEN'(BYTES);
                            mem_wstrb <= hiStrb;
                            mem_wdata <= hiData;
                        end else begin
                            state     <= Idle;
                            mem_valid <= 1'b0;
                            mem_addr  <= '0;
                            mem_wstrb <= '0;
                            mem_wdata <= '0;
                        end
                    end
                end
                Beat1: begin
                    if (mem_ready) begin
                        state     <= Idle;
                        mem_valid <= 1'b0;
                        mem_addr  <= '0;
                        mem_wstrb <= '0;
                        mem_wdata <= '0;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_misaligned_store_unit.sv
// Drives three configurations (32/split, 32/trap, 64/split) with shared stimulus and
// compares each cycle against a per-configuration beat-list model.
module tb_misaligned_store_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        reqValid;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        memReady;

    always #5 CLK = ~CLK;

    logic        rdy[3];
    logic        mv[3];
    logic        dn[3];
    logic        ft[3];
    logic [63:0] ma[3];
    logic [63:0] md[3];
    logic [7:0]  ms[3];

    logic [31:0] ma0, md0, ma1, md1;
    logic [3:0]  ms0, ms1;
    logic [63:0] ma2, md2;
    logic [7:0]  ms2;

    assign ma[0] = {32'd0, ma0};
    assign md[0] = {32'd0, md0};
    assign ms[0] = {4'd0, ms0};
    assign ma[1] = {32'd0, ma1};
    assign md[1] = {32'd0, md1};
    assign ms[1] = {4'd0, ms1};
    assign ma[2] = ma2;
    assign md[2] = md2;
    assign ms[2] = ms2;

    misaligned_store_unit #(.XLEN(32), .SPLIT_EN(1'b1)) u0 (
        .CLK(CLK), .RESET(RESET), .req_valid(reqValid), .req_ready(rdy[0]),
        .funct3(funct3), .addr(addr[31:0]), .wdata(wdata[31:0]), .mem_valid(mv[0]),
        .mem_ready(memReady), .mem_addr(ma0), .mem_wdata(md0), .mem_wstrb(ms0),
        .store_done(dn[0]), .store_fault(ft[0])
    );

    misaligned_store_unit #(.XLEN(32), .SPLIT_EN(1'b0)) u1 (
        .CLK(CLK), .RESET(RESET), .req_valid(reqValid), .req_ready(rdy[1]),
        .funct3(funct3), .addr(addr[31:0]), .wdata(wdata[31:0]), .mem_valid(mv[1]),
        .mem_ready(memReady), .mem_addr(ma1), .mem_wdata(md1), .mem_wstrb(ms1),
        .store_done(dn[1]), .store_fault(ft[1])
    );

    misaligned_store_unit #(.XLEN(64), .SPLIT_EN(1'b1)) u2 (
        .CLK(CLK), .RESET(RESET), .req_valid(reqValid), .req_ready(rdy[2]),
        .funct3(funct3), .addr(addr), .wdata(wdata), .mem_valid(mv[2]),
        .mem_ready(memReady), .mem_addr(ma2), .mem_wdata(md2), .mem_wstrb(ms2),
        .store_done(dn[2]), .store_fault(ft[2])
    );

    int xlenCfg[3]  = '{32, 32, 64};
    bit splitCfg[3] = '{1'b1, 1'b0, 1'b1};

    bit          busy[3];
    bit          faultPend[3];
    int          cur[3];
    int          nBeats[3];
    logic [63:0] bAddr[3][2];
    logic [7:0]  bStrb[3][2];
    logic [63:0] bData[3][2];

    int numChecks = 0;
    int numErrors = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Builds the expected beat list for a store accepted by configuration i.
    task automatic modelAccept(input int i);
        int           xl;
        int           nb;
        int           n;
        int           off;
        logic [63:0]  a;
        logic [63:0]  w;
        logic [63:0]  base;
        logic [63:0]  wrapMask;
        logic [127:0] d;
        logic [15:0]  m;
        xl       = xlenCfg[i];
        nb       = xl / 8;
        n        = 1 << funct3[1:0];
        a        = (xl == 32) ? {32'd0, addr[31:0]} : addr;
        w        = (xl == 32) ? {32'd0, wdata[31:0]} : wdata;
        wrapMask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        off      = int'(a % 64'(nb));
        if (xl == 32 && n == 8) begin
            faultPend[i] = 1'b1;
        end else if (!splitCfg[i] && (off % n) != 0) begin
            faultPend[i] = 1'b1;
        end else begin
            base        = a - 64'(off);
            d           = 128'(w) << (8 * off);
            m           = 16'(((1 << n) - 1) << off);
            bAddr[i][0] = base;
            bStrb[i][0] = 8'(m & 16'((1 << nb) - 1));
            bData[i][0] = 64'(d & ((128'd1 << xl) - 128'd1));
            bAddr[i][1] = (base + 64'(nb)) & wrapMask;
            bStrb[i][1] = 8'(m >> nb);
            bData[i][1] = 64'(d >> xl);
            nBeats[i]   = (off + n > nb) ? 2 : 1;
            cur[i]      = 0;
            busy[i]     = 1'b1;
        end
    endtask

    task automatic advanceModel();
        for (int i = 0; i < 3; i++) begin
            if (RESET) begin
                busy[i]      = 1'b0;
                faultPend[i] = 1'b0;
            end else if (busy[i]) begin
                faultPend[i] = 1'b0;
                if (memReady) begin
                    if (cur[i] == nBeats[i] - 1) busy[i] = 1'b0;
                    else cur[i] = cur[i] + 1;
                end
            end else begin
                faultPend[i] = 1'b0;
                if (reqValid) modelAccept(i);
            end
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("u%0d.req_ready", i), 64'(rdy[i]), 64'(!busy[i]));
            checkVal($sformatf("u%0d.mem_valid", i), 64'(mv[i]), 64'(busy[i]));
            checkVal($sformatf("u%0d.store_done", i), 64'(dn[i]),
                     64'(busy[i] && memReady && (cur[i] == nBeats[i] - 1)));
            checkVal($sformatf("u%0d.store_fault", i), 64'(ft[i]), 64'(faultPend[i]));
            if (busy[i]) begin
                checkVal($sformatf("u%0d.mem_addr", i), ma[i], bAddr[i][cur[i]]);
                checkVal($sformatf("u%0d.mem_wstrb", i), 64'(ms[i]), 64'(bStrb[i][cur[i]]));
                checkVal($sformatf("u%0d.mem_wdata", i), md[i], bData[i][cur[i]]);
            end else begin
                checkVal($sformatf("u%0d.idle_wstrb", i), 64'(ms[i]), 64'd0);
                checkVal($sformatf("u%0d.idle_wdata", i), md[i], 64'd0);
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        checkAll();
        @(posedge CLK);
        advanceModel();
        #1;
    endtask

    task automatic drive(input logic rv, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic mr);
        RESET    = 1'b0;
        reqValid = rv;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        memReady = mr;
    endtask

    initial begin
        RESET    = 1'b1;
        reqValid = 1'b0;
        funct3   = 3'd0;
        addr     = '0;
        wdata    = '0;
        memReady = 1'b0;
        repeat (2) @(posedge CLK);
        advanceModel();
        #1;

        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("rst_u%0d_addr", i), ma[i], 64'd0);
            checkVal($sformatf("rst_u%0d_ready", i), 64'(rdy[i]), 64'd1);
        end
        step();

        // SW crossing a word boundary
        drive(1'b1, 3'b010, 64'h1003, 64'hAABB_CCDD, 1'b1);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("sw_b0_addr", ma[0], 64'h1000);
        checkVal("sw_b0_strb", 64'(ms[0]), 64'b1000);
        checkVal("sw_b0_data", md[0], 64'hDD00_0000);
        checkVal("sw_b0_done", 64'(dn[0]), 64'd0);
        checkVal("sw_trap_fault", 64'(ft[1]), 64'd1);
        checkVal("sw_trap_valid", 64'(mv[1]), 64'd0);
        checkVal("sw_trap_ready", 64'(rdy[1]), 64'd1);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("sw_b1_addr", ma[0], 64'h1004);
        checkVal("sw_b1_strb", 64'(ms[0]), 64'b0111);
        checkVal("sw_b1_data", md[0], 64'h00AA_BBCC);
        checkVal("sw_b1_done", 64'(dn[0]), 64'd1);
        step();
        step();

        // SH, single beat, done one cycle after acceptance
        drive(1'b1, 3'b001, 64'h2002, 64'h0000_1234, 1'b1);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("sh_addr", ma[0], 64'h2000);
        checkVal("sh_strb", 64'(ms[0]), 64'b1100);
        checkVal("sh_data", md[0], 64'h1234_0000);
        checkVal("sh_done", 64'(dn[0]), 64'd1);
        checkVal("sh_trap_done", 64'(dn[1]), 64'd1);
        step();

        // Misaligned SW with trapping configuration
        drive(1'b1, 3'b010, 64'h1001, 64'h1111_2222, 1'b1);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("trap_fault", 64'(ft[1]), 64'd1);
        checkVal("trap_valid", 64'(mv[1]), 64'd0);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("trap_fault_pulse", 64'(ft[1]), 64'd0);
        checkVal("trap_ready", 64'(rdy[1]), 64'd1);
        step();
        step();

        // SH at the top of the 32-bit space wraps the second beat to 0
        drive(1'b1, 3'b001, 64'hFFFF_FFFF, 64'hBEEF, 1'b1);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("wrap_b0_addr", ma[0], 64'hFFFF_FFFC);
        checkVal("wrap_b0_strb", 64'(ms[0]), 64'b1000);
        checkVal("wrap_b0_data", md[0], 64'hEF00_0000);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("wrap_b1_addr", ma[0], 64'h0);
        checkVal("wrap_b1_strb", 64'(ms[0]), 64'b0001);
        checkVal("wrap_b1_data", md[0], 64'h0000_00BE);
        step();
        step();

        // Backpressure during BEAT0
        drive(1'b1, 3'b010, 64'h1003, 64'hAABB_CCDD, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
            #2;
            checkVal("stall_valid", 64'(mv[0]), 64'd1);
            checkVal("stall_addr", ma[0], 64'h1000);
            checkVal("stall_strb", 64'(ms[0]), 64'b1000);
            checkVal("stall_data", md[0], 64'hDD00_0000);
            checkVal("stall_done", 64'(dn[0]), 64'd0);
            step();
        end
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("stall_final_done", 64'(dn[0]), 64'd1);
        step();
        step();

        // Reset while in BEAT1
        drive(1'b1, 3'b010, 64'h1003, 64'hAABB_CCDD, 1'b1);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
        RESET = 1'b1;
        #2;
        checkVal("rstb1_pre_valid", 64'(mv[0]), 64'd1);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("rstb1_valid", 64'(mv[0]), 64'd0);
        checkVal("rstb1_ready", 64'(rdy[0]), 64'd1);
        checkVal("rstb1_done", 64'(dn[0]), 64'd0);
        checkVal("rstb1_addr", ma[0], 64'd0);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("rstb1_no_beat", 64'(mv[0]), 64'd0);
        step();

        // SD at offset 4 on the 64-bit unit splits 4/4
        drive(1'b1, 3'b011, 64'h4004, 64'h1122_3344_5566_7788, 1'b1);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("sd_b0_addr", ma[2], 64'h4000);
        checkVal("sd_b0_strb", 64'(ms[2]), 64'hF0);
        checkVal("sd_b0_data", md[2], 64'h5566_7788_0000_0000);
        checkVal("sd_illegal_fault", 64'(ft[0]), 64'd1);
        step();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        checkVal("sd_b1_addr", ma[2], 64'h4008);
        checkVal("sd_b1_strb", 64'(ms[2]), 64'h0F);
        checkVal("sd_b1_data", md[2], 64'h0000_0000_1122_3344);
        checkVal("sd_b1_done", 64'(dn[2]), 64'd1);
        step();

        for (int c = 0; c < 3000; c++) begin
            RESET    = ($urandom_range(0, 99) == 0);
            reqValid = ($urandom_range(0, 2) != 0);
            funct3   = 3'($urandom);
            addr     = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) begin
                addr = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            end
            wdata    = {$urandom, $urandom};
            memReady = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
